// File: rtl/ttt_game_ctrl.sv
// Tic-tac-toe game sequencer: takes moves over valid/ready, writes the board,
// alternates turns, detects win/tie and enforces an optional per-move timeout.
//
// Ports:
//   clk, reset       - rising-edge clock, synchronous active-high reset
//   new_game         - synchronous clear of board and game state
//   move_valid/cell  - move request and target cell (0..8 legal)
//   move_ready       - high in WAIT, decoded from state
//   move_accept/rej  - one-cycle result pulse for the previous request
//   board            - cell i at [2i+1:2i]: 00 empty, 01 P1, 10 P2
//   turn             - player to move (01/10), 00 once the game is over
//   status/game_over - 00 running, 01 P1 won, 10 P2 won, 11 tie
module ttt_game_ctrl #(
    parameter int FIRST_PLAYER = 1,
    parameter int MOVE_TIMEOUT = 0,
    parameter int TMR_W        = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        new_game,
    input  logic        move_valid,
    input  logic [3:0]  move_cell,
    output logic        move_ready,
    output logic        move_accept,
    output logic        move_reject,
    output logic [17:0] board,
    output logic [1:0]  turn,
    output logic [1:0]  status,
    output logic        game_over
);

    localparam logic [1:0] S_WAIT  = 2'd0;
    localparam logic [1:0] S_CHECK = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    localparam logic [1:0] FIRST_CODE =
        (FIRST_PLAYER == 2) ? 2'b10 : 2'b01;

    logic [1:0]       state_q, state_d;
    logic [17:0]      board_q, board_d;
    logic [1:0]       turn_q, turn_d;
    logic [1:0]       status_q, status_d;
    logic             accept_q, accept_d;
    logic             reject_q, reject_d;
    logic [TMR_W-1:0] timer_q, timer_d;

    logic       cell_empty;
    logic       legal;
    logic       full;
    logic [1:0] win;
    logic       timeout_hit;

    // Code of a line if all three cells hold the same player, else 00.
    function automatic logic [1:0] line_code(
        input logic [17:0] b,
        input int          a,
        input int          m,
        input int          c
    );
        logic [1:0] x;
        x = b[2*a +: 2];
        if (x != 2'b00 && x == b[2*m +: 2] && x == b[2*c +: 2])
            return x;
        return 2'b00;
    endfunction

    always_comb begin
        cell_empty = 1'b0;
        full       = 1'b1;
        for (int i = 0; i < 9; i++) begin
            if (move_cell == 4'(i))
                cell_empty = (board_q[2*i +: 2] == 2'b00);
            if (board_q[2*i +: 2] == 2'b00)
                full = 1'b0;
        end
    end

    assign legal = move_valid && (state_q == S_WAIT) &&
                   (move_cell <= 4'd8) && cell_empty;

    // The board is checked after every move, so winning lines can only
    // belong to the player who just moved; OR-ing the codes is safe.
    assign win = line_code(board_q, 0, 1, 2) | line_code(board_q, 3, 4, 5) |
                 line_code(board_q, 6, 7, 8) | line_code(board_q, 0, 3, 6) |
                 line_code(board_q, 1, 4, 7) | line_code(board_q, 2, 5, 8) |
                 line_code(board_q, 0, 4, 8) | line_code(board_q, 2, 4, 6);

    assign timeout_hit = (MOVE_TIMEOUT > 0) &&
                         (timer_q == TMR_W'(MOVE_TIMEOUT - 1));

    always_comb begin
        state_d  = state_q;
        board_d  = board_q;
        turn_d   = turn_q;
        status_d = status_q;
        timer_d  = timer_q;
        accept_d = 1'b0;
        reject_d = 1'b0;
        if (new_game) begin
            state_d  = S_WAIT;
            board_d  = '0;
            turn_d   = FIRST_CODE;
            status_d = 2'b00;
            timer_d  = '0;
        end else begin
            unique case (state_q)
                S_WAIT: begin
                    if (timer_q != '1)
                        timer_d = timer_q + TMR_W'(1);
                    if (move_valid && !legal)
                        reject_d = 1'b1;
                    if (legal) begin
                        for (int i = 0; i < 9; i++)
                            if (move_cell == 4'(i))
                                board_d[2*i +: 2] = turn_q;
                        accept_d = 1'b1;
                        state_d  = S_CHECK;
                    end else if (timeout_hit) begin
                        status_d = turn_q ^ 2'b11;
                        turn_d   = 2'b00;
                        state_d  = S_DONE;
                    end
                end
                S_CHECK: begin
                    timer_d = '0;
                    if (win != 2'b00 || full) begin
                        status_d = (win != 2'b00) ? win : 2'b11;
                        turn_d   = 2'b00;
                        state_d  = S_DONE;
                    end else begin
                        turn_d  = turn_q ^ 2'b11;
                        state_d = S_WAIT;
                    end
                end
                S_DONE: ;
                default: state_d = S_WAIT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_WAIT;
            board_q  <= '0;
            turn_q   <= FIRST_CODE;
            status_q <= 2'b00;
            timer_q  <= '0;
            accept_q <= 1'b0;
            reject_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            board_q  <= board_d;
            turn_q   <= turn_d;
            status_q <= status_d;
            timer_q  <= timer_d;
            accept_q <= accept_d;
            reject_q <= reject_d;
        end
    end

    assign move_ready  = (state_q == S_WAIT);
    assign move_accept = accept_q;
    assign move_reject = reject_q;
    assign board       = board_q;
    assign turn        = turn_q;
    assign status      = status_q;
    assign game_over   = (status_q != 2'b00);

endmodule

// File: tb/tb_ttt_game_ctrl.sv
// Self-checking bench for ttt_game_ctrl: directed games plus random moves
// compared every cycle against a cell-array reference model.
module tb_ttt_game_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        new_game;
    logic        move_valid;
    logic [3:0]  move_cell;
    logic        move_ready;
    logic        move_accept;
    logic        move_reject;
    logic [17:0] board;
    logic [1:0]  turn;
    logic [1:0]  status;
    logic        game_over;

    int n_cmp = 0;
    int n_bad = 0;

    ttt_game_ctrl #(
        .FIRST_PLAYER(1),
        .MOVE_TIMEOUT(10),
        .TMR_W(8)
    ) dut (
        .clk(clk),
        .reset(reset),
        .new_game(new_game),
        .move_valid(move_valid),
        .move_cell(move_cell),
        .move_ready(move_ready),
        .move_accept(move_accept),
        .move_reject(move_reject),
        .board(board),
        .turn(turn),
        .status(status),
        .game_over(game_over)
    );

    always #5 clk = ~clk;

    // Reference model: plain game rules.
    int cell_m[9];
    int who_m;
    int res_m;
    bit chk_m;
    bit over_m;
    int idle_m;
    bit acc_m;
    bit rej_m;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 9; i++) cell_m[i] = 0;
        who_m  = 1;
        res_m  = 0;
        chk_m  = 0;
        over_m = 0;
        idle_m = 0;
        acc_m  = 0;
        rej_m  = 0;
    endtask

    function automatic int winner();
        for (int r = 0; r < 3; r++)
            if (cell_m[3*r] != 0 && cell_m[3*r] == cell_m[3*r+1] &&
                cell_m[3*r+1] == cell_m[3*r+2])
                return cell_m[3*r];
        for (int k = 0; k < 3; k++)
            if (cell_m[k] != 0 && cell_m[k] == cell_m[k+3] &&
                cell_m[k+3] == cell_m[k+6])
                return cell_m[k];
        if (cell_m[4] != 0 && cell_m[0] == cell_m[4] && cell_m[4] == cell_m[8])
            return cell_m[4];
        if (cell_m[4] != 0 && cell_m[2] == cell_m[4] && cell_m[4] == cell_m[6])
            return cell_m[4];
        return 0;
    endfunction

    function automatic bit is_full();
        for (int i = 0; i < 9; i++)
            if (cell_m[i] == 0) return 0;
        return 1;
    endfunction

    task automatic model_step(input bit rst, input bit ng, input bit v,
                              input int c);
        bit lg;
        int w;
        if (rst || ng) begin
            model_clear();
            return;
        end
        acc_m = 0;
        rej_m = 0;
        if (chk_m) begin
            chk_m = 0;
            idle_m = 0;
            w = winner();
            if (w != 0) res_m = w;
            else if (is_full()) res_m = 3;
            if (res_m != 0) over_m = 1;
            else who_m = 3 - who_m;
        end else if (!over_m) begin
            lg = v && c <= 8 && cell_m[c % 9] == 0;
            if (v && !lg) rej_m = 1;
            if (lg) begin
                cell_m[c] = who_m;
                acc_m = 1;
                chk_m = 1;
            end else if (idle_m == 9) begin
                res_m = 3 - who_m;
                over_m = 1;
            end else begin
                idle_m++;
            end
        end
    endtask

    task automatic compare_all();
        logic [17:0] b;
        b = '0;
        for (int i = 0; i < 9; i++) b[2*i +: 2] = 2'(cell_m[i]);
        check("board", 32'(board), 32'(b));
        check("turn", 32'(turn), over_m ? 32'd0 : 32'(who_m));
        check("status", 32'(status), 32'(res_m));
        check("game_over", 32'(game_over), 32'(res_m != 0));
        check("move_accept", 32'(move_accept), 32'(acc_m));
        check("move_reject", 32'(move_reject), 32'(rej_m));
        check("move_ready", 32'(move_ready), 32'(!chk_m && !over_m));
    endtask

    task automatic cycle(input bit rst, input bit ng, input bit v,
                         input int c);
        reset      = rst;
        new_game   = ng;
        move_valid = v;
        move_cell  = 4'(c);
        @(posedge clk);
        model_step(rst, ng, v, c);
        #1;
        compare_all();
    endtask

    // Issue a move, then one idle cycle covering the CHECK state.
    task automatic play(input int c);
        cycle(0, 0, 1, c);
        cycle(0, 0, 0, 0);
    endtask

    int seq_draw[9] = '{0, 1, 2, 4, 3, 5, 7, 6, 8};
    int seq_win9[9] = '{2, 0, 3, 1, 6, 4, 7, 5, 8};
    int seq_p1[5]   = '{0, 3, 1, 4, 2};

    initial begin
        bit ng;
        bit v;
        int c;
        reset = 1'b1;
        new_game = 1'b0;
        move_valid = 1'b0;
        move_cell = '0;
        cycle(1, 0, 0, 0);
        cycle(1, 0, 0, 0);
        check("reset_turn", 32'(turn), 32'd1);

        // P1 wins on the top row.
        for (int i = 0; i < 5; i++) play(seq_p1[i]);
        check("row_win_status", 32'(status), 32'd1);
        check("row_win_cells", 32'(board[5:0]), 32'b010101);
        cycle(0, 0, 1, 5);

        // Occupied cell and out-of-range cells are rejected.
        cycle(0, 1, 0, 0);
        play(4);
        play(4);
        check("occupied_turn", 32'(turn), 32'd2);
        play(9);
        play(15);

        // Full board without a line, then a ninth move that wins.
        cycle(0, 1, 0, 0);
        for (int i = 0; i < 9; i++) play(seq_draw[i]);
        check("draw_status", 32'(status), 32'd3);
        cycle(0, 1, 0, 0);
        for (int i = 0; i < 9; i++) play(seq_win9[i]);
        check("win9_status", 32'(status), 32'd1);

        // Idle timeout forfeits, a move on the last cycle saves it.
        cycle(0, 1, 0, 0);
        for (int i = 0; i < 10; i++) cycle(0, 0, 0, 0);
        check("timeout_status", 32'(status), 32'd2);
        cycle(0, 1, 0, 0);
        for (int i = 0; i < 9; i++) cycle(0, 0, 0, 0);
        play(4);
        check("late_move_status", 32'(status), 32'd0);

        // new_game during CHECK and alongside a move request.
        cycle(0, 0, 1, 0);
        cycle(0, 1, 0, 0);
        check("ng_check_board", 32'(board), 32'd0);
        play(2);
        cycle(0, 1, 1, 3);
        check("ng_move_board", 32'(board), 32'd0);

        // Random play.
        for (int n = 0; n < 1500; n++) begin
            ng = ($urandom % 40 == 0) || (over_m && $urandom % 4 == 0);
            v  = ($urandom % 2 == 0);
            c  = ($urandom % 4 == 0) ? int'($urandom % 16)
                                     : int'($urandom % 9);
            cycle(0, ng, v, c);
        end
        cycle(1, 0, 1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
